// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM encoding, flush/stall
// source priority and the bundle of per-stage control bits.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Encoded in ascending priority so a larger value always wins.
  typedef enum logic [2:0] {
    SRC_NONE     = 3'd0,
    SRC_BUSY     = 3'd1,
    SRC_LOAD_USE = 3'd2,
    SRC_JUMP     = 3'd3,
    SRC_EXCP     = 3'd4
  } src_e;

  typedef struct packed {
    logic if_stall;
    logic id_stall;
    logic ex_stall;
    logic if_flush;
    logic id_flush;
    logic ex_flush;
    logic mem_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  function automatic src_e pick_src(input logic excp, input logic jump,
                                    input logic load_use, input logic busy);
    if (excp)     return SRC_EXCP;
    if (jump)     return SRC_JUMP;
    if (load_use) return SRC_LOAD_USE;
    if (busy)     return SRC_BUSY;
    return SRC_NONE;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the source operands in ID.
// Purely combinational; x0 never creates a dependency.
module pipe_hazard_ctrl_hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_load_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_i,
  input  logic                  id_rs1_re_i,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_i,
  input  logic                  id_rs2_re_i,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_i,
  output logic                  load_use_o
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit    = id_rs1_re_i && (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit    = id_rs2_re_i && (id_rs2_addr_i == ex_rd_addr_i);
  assign load_use_o = ex_load_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush arbiter with a pending-redirect FSM that holds the
// redirect target until fetch accepts it, plus an optional post-exception drain.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int PC_WIDTH     = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int DRAIN_CYCLES = 2,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_jump_i,
  input  logic [PC_WIDTH-1:0]    ex_jump_pc_i,
  input  logic                   mem_excp_i,
  input  logic [PC_WIDTH-1:0]    mem_excp_pc_i,
  input  logic                   ex_load_i,
  input  logic [REG_ADDR_W-1:0]  ex_rd_addr_i,
  input  logic                   id_rs1_re_i,
  input  logic [REG_ADDR_W-1:0]  id_rs1_addr_i,
  input  logic                   id_rs2_re_i,
  input  logic [REG_ADDR_W-1:0]  id_rs2_addr_i,
  input  logic                   ex_busy_i,
  input  logic                   if_ready_i,
  output logic                   if_stall_o,
  output logic                   id_stall_o,
  output logic                   ex_stall_o,
  output logic                   if_flush_o,
  output logic                   id_flush_o,
  output logic                   ex_flush_o,
  output logic                   mem_flush_o,
  output logic                   redirect_valid_o,
  output logic [PC_WIDTH-1:0]    flush_pc_o,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  localparam int DRAIN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int DRAIN_INIT_I = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_INIT_I);

  state_e                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pend_pc_q, pend_pc_d;
  logic [DRAIN_W-1:0]      drain_cnt_q, drain_cnt_d;
  logic [STALL_CNT_W-1:0]  stall_cnt_q;

  logic                    load_use;
  src_e                    src;
  ctrl_t                   ctrl;
  logic                    redirect_valid;
  logic [PC_WIDTH-1:0]     flush_pc;

  pipe_hazard_ctrl_hazard_detect #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_hazard_detect (
    .ex_load_i    (ex_load_i),
    .ex_rd_addr_i (ex_rd_addr_i),
    .id_rs1_re_i  (id_rs1_re_i),
    .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs2_re_i  (id_rs2_re_i),
    .id_rs2_addr_i(id_rs2_addr_i),
    .load_use_o   (load_use)
  );

  assign src = pick_src(mem_excp_i, ex_jump_i, load_use, ex_busy_i);

  always_comb begin
    state_d        = state_q;
    pend_pc_d      = pend_pc_q;
    drain_cnt_d    = drain_cnt_q;
    ctrl           = CTRL_IDLE;
    redirect_valid = 1'b0;
    flush_pc       = '0;

    if (src == SRC_EXCP) begin
      // An exception wins in every state; the newest trap vector replaces any pending one.
      ctrl.if_flush  = 1'b1;
      ctrl.id_flush  = 1'b1;
      ctrl.ex_flush  = 1'b1;
      ctrl.mem_flush = 1'b1;
      pend_pc_d      = mem_excp_pc_i;
      drain_cnt_d    = DRAIN_INIT;
      if (DRAIN_CYCLES > 0) state_d = ST_DRAIN;
      else                  state_d = ST_WAIT;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          case (src)
            SRC_JUMP: begin
              ctrl.if_flush  = 1'b1;
              ctrl.id_flush  = 1'b1;
              redirect_valid = 1'b1;
              flush_pc       = ex_jump_pc_i;
              if (!if_ready_i) begin
                pend_pc_d = ex_jump_pc_i;
                state_d   = ST_WAIT;
              end
            end
            SRC_LOAD_USE: begin
              ctrl.if_stall = 1'b1;
              ctrl.id_stall = 1'b1;
              ctrl.id_flush = 1'b1;
            end
            SRC_BUSY: begin
              ctrl.if_stall = 1'b1;
              ctrl.id_stall = 1'b1;
              ctrl.ex_stall = 1'b1;
              ctrl.ex_flush = 1'b1;
            end
            default: ;
          endcase
        end
        ST_DRAIN: begin
          ctrl.if_stall = 1'b1;
          ctrl.if_flush = 1'b1;
          if (drain_cnt_q == '0) state_d = ST_WAIT;
          else                   drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
        ST_WAIT: begin
          ctrl.if_stall  = 1'b1;
          ctrl.if_flush  = 1'b1;
          redirect_valid = 1'b1;
          flush_pc       = pend_pc_q;
          if (if_ready_i) state_d = ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State / pending redirect registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      pend_pc_q   <= '0;
      drain_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (ctrl.if_stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  assign if_stall_o       = ctrl.if_stall;
  assign id_stall_o       = ctrl.id_stall;
  assign ex_stall_o       = ctrl.ex_stall;
  assign if_flush_o       = ctrl.if_flush;
  assign id_flush_o       = ctrl.id_flush;
  assign ex_flush_o       = ctrl.ex_flush;
  assign mem_flush_o      = ctrl.mem_flush;
  assign redirect_valid_o = redirect_valid;
  assign flush_pc_o       = flush_pc;
  assign stall_cnt_o      = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (DRAIN_CYCLES=2, 4-bit stall counter).
module tb_pipe_hazard_ctrl;

  localparam int PW = 32;
  localparam int RW = 5;
  localparam int CW = 4;

  // Expected control vectors: {if_stall,id_stall,ex_stall,if_flush,id_flush,ex_flush,mem_flush,redirect}
  localparam logic [7:0] V_IDLE = 8'h00;
  localparam logic [7:0] V_LU   = 8'hC8;
  localparam logic [7:0] V_BUSY = 8'hE4;
  localparam logic [7:0] V_JUMP = 8'h19;
  localparam logic [7:0] V_EXCP = 8'h1E;
  localparam logic [7:0] V_DRN  = 8'h90;
  localparam logic [7:0] V_WT   = 8'h91;

  logic          clk;
  logic          rst_n;
  logic          ex_jump_i;
  logic [PW-1:0] ex_jump_pc_i;
  logic          mem_excp_i;
  logic [PW-1:0] mem_excp_pc_i;
  logic          ex_load_i;
  logic [RW-1:0] ex_rd_addr_i;
  logic          id_rs1_re_i;
  logic [RW-1:0] id_rs1_addr_i;
  logic          id_rs2_re_i;
  logic [RW-1:0] id_rs2_addr_i;
  logic          ex_busy_i;
  logic          if_ready_i;
  logic          if_stall_o, id_stall_o, ex_stall_o;
  logic          if_flush_o, id_flush_o, ex_flush_o, mem_flush_o;
  logic          redirect_valid_o;
  logic [PW-1:0] flush_pc_o;
  logic [CW-1:0] stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  pipe_hazard_ctrl #(
    .PC_WIDTH    (PW),
    .REG_ADDR_W  (RW),
    .DRAIN_CYCLES(2),
    .STALL_CNT_W (CW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_jump_i       (ex_jump_i),
    .ex_jump_pc_i    (ex_jump_pc_i),
    .mem_excp_i      (mem_excp_i),
    .mem_excp_pc_i   (mem_excp_pc_i),
    .ex_load_i       (ex_load_i),
    .ex_rd_addr_i    (ex_rd_addr_i),
    .id_rs1_re_i     (id_rs1_re_i),
    .id_rs1_addr_i   (id_rs1_addr_i),
    .id_rs2_re_i     (id_rs2_re_i),
    .id_rs2_addr_i   (id_rs2_addr_i),
    .ex_busy_i       (ex_busy_i),
    .if_ready_i      (if_ready_i),
    .if_stall_o      (if_stall_o),
    .id_stall_o      (id_stall_o),
    .ex_stall_o      (ex_stall_o),
    .if_flush_o      (if_flush_o),
    .id_flush_o      (id_flush_o),
    .ex_flush_o      (ex_flush_o),
    .mem_flush_o     (mem_flush_o),
    .redirect_valid_o(redirect_valid_o),
    .flush_pc_o      (flush_pc_o),
    .stall_cnt_o     (stall_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [7:0] ctrl_vec;
  assign ctrl_vec = {if_stall_o, id_stall_o, ex_stall_o, if_flush_o,
                     id_flush_o, ex_flush_o, mem_flush_o, redirect_valid_o};

  // A register is never both held and bubbled; jumps only arrive while running.
  always @(negedge clk) begin
    if (rst_n) begin
      n_vec++;
      assert (!(id_stall_o && if_flush_o) && !(ex_stall_o && id_flush_o)) else begin
        n_err++;
        $error("FAIL stage_excl observed=%b expected no stall+flush overlap", ctrl_vec);
      end
      n_vec++;
      assert (!(ex_jump_i && if_stall_o && if_flush_o)) else begin
        n_err++;
        $error("FAIL jump_outside_run observed=%b expected no jump while redirecting", ctrl_vec);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_jump_i = 1'b0;  ex_jump_pc_i = '0;
    mem_excp_i = 1'b0; mem_excp_pc_i = '0;
    ex_load_i = 1'b0;  ex_rd_addr_i = '0;
    id_rs1_re_i = 1'b0; id_rs1_addr_i = '0;
    id_rs2_re_i = 1'b0; id_rs2_addr_i = '0;
    ex_busy_i = 1'b0;  if_ready_i = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] exp_ctrl, input logic [PW-1:0] exp_pc);
    #1;
    n_vec++;
    assert (ctrl_vec === exp_ctrl) else begin
      n_err++;
      $error("FAIL %s ctrl observed=%b expected=%b", tag, ctrl_vec, exp_ctrl);
    end
    n_vec++;
    assert (flush_pc_o === exp_pc) else begin
      n_err++;
      $error("FAIL %s flush_pc observed=%h expected=%h", tag, flush_pc_o, exp_pc);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] exp_cnt);
    n_vec++;
    assert (stall_cnt_o === exp_cnt) else begin
      n_err++;
      $error("FAIL %s stall_cnt observed=%0d expected=%0d", tag, stall_cnt_o, exp_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    chk("reset", V_IDLE, 32'h0);
    chk_cnt("reset", 4'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Load-use on rs1, then rd=x0, then rs2, then rs1 match without read enable
    ex_load_i = 1'b1; ex_rd_addr_i = 5'd5; id_rs1_re_i = 1'b1; id_rs1_addr_i = 5'd5;
    chk("lu_rs1", V_LU, 32'h0);
    tick(); idle_inputs();
    chk("lu_done", V_IDLE, 32'h0);
    chk_cnt("lu_cnt", 4'd1);
    ex_load_i = 1'b1; ex_rd_addr_i = 5'd0; id_rs1_re_i = 1'b1; id_rs1_addr_i = 5'd0;
    chk("lu_x0", V_IDLE, 32'h0);
    tick(); idle_inputs();
    chk_cnt("lu_x0_cnt", 4'd1);
    ex_load_i = 1'b1; ex_rd_addr_i = 5'd7; id_rs2_re_i = 1'b1; id_rs2_addr_i = 5'd7;
    id_rs1_addr_i = 5'd7;
    chk("lu_rs2", V_LU, 32'h0);
    tick(); idle_inputs();
    chk_cnt("lu_rs2_cnt", 4'd2);
    ex_load_i = 1'b1; ex_rd_addr_i = 5'd9; id_rs1_addr_i = 5'd9; id_rs2_re_i = 1'b1;
    id_rs2_addr_i = 5'd3;
    chk("lu_no_re", V_IDLE, 32'h0);
    tick(); idle_inputs();

    // Jump accepted by fetch in the same cycle
    ex_jump_i = 1'b1; ex_jump_pc_i = 32'h0000_0100; if_ready_i = 1'b1;
    chk("jmp_rdy", V_JUMP, 32'h0000_0100);
    tick(); idle_inputs();
    chk("jmp_rdy_run", V_IDLE, 32'h0);

    // Jump while fetch not ready: redirect held from the pending register
    ex_jump_i = 1'b1; ex_jump_pc_i = 32'h0000_0200;
    chk("jmp_nrdy0", V_JUMP, 32'h0000_0200);
    tick(); idle_inputs(); ex_jump_pc_i = 32'hDEAD_BEEF;
    chk("jmp_wait1", V_WT, 32'h0000_0200);
    tick();
    chk("jmp_wait2", V_WT, 32'h0000_0200);
    tick(); if_ready_i = 1'b1;
    chk("jmp_wait3", V_WT, 32'h0000_0200);
    tick(); idle_inputs();
    chk("jmp_resume", V_IDLE, 32'h0);
    chk_cnt("jmp_cnt", 4'd5);

    // Exception with a two-cycle drain
    mem_excp_i = 1'b1; mem_excp_pc_i = 32'h8000_0000;
    chk("exc_c0", V_EXCP, 32'h0);
    tick(); idle_inputs();
    chk("exc_c1", V_DRN, 32'h0);
    tick();
    chk("exc_c2", V_DRN, 32'h0);
    tick(); if_ready_i = 1'b1;
    chk("exc_c3", V_WT, 32'h8000_0000);
    tick(); idle_inputs();
    chk("exc_run", V_IDLE, 32'h0);
    chk_cnt("exc_cnt", 4'd8);

    // All sources at once: only the exception response
    mem_excp_i = 1'b1; mem_excp_pc_i = 32'h0000_1234;
    ex_jump_i = 1'b1; ex_jump_pc_i = 32'h0000_0999; if_ready_i = 1'b1;
    ex_load_i = 1'b1; ex_rd_addr_i = 5'd4; id_rs1_re_i = 1'b1; id_rs1_addr_i = 5'd4;
    ex_busy_i = 1'b1;
    chk("all_src", V_EXCP, 32'h0);
    tick(); idle_inputs();
    chk("all_drn1", V_DRN, 32'h0);
    tick();
    chk("all_drn2", V_DRN, 32'h0);
    tick();
    chk("all_wait", V_WT, 32'h0000_1234);

    // Newer exception during WAIT replaces the pending target and restarts drain
    mem_excp_i = 1'b1; mem_excp_pc_i = 32'h0000_5678;
    chk("re_excp", V_EXCP, 32'h0);
    tick(); idle_inputs();
    chk("re_drn1", V_DRN, 32'h0);
    tick();
    chk("re_drn2", V_DRN, 32'h0);
    tick();
    chk("re_wait", V_WT, 32'h0000_5678);

    // Asynchronous reset in the middle of WAIT
    rst_n = 1'b0;
    chk("rst_wait", V_IDLE, 32'h0);
    chk_cnt("rst_wait", 4'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_run", V_IDLE, 32'h0);

    // Priority: jump over load-use, load-use over busy
    ex_jump_i = 1'b1; ex_jump_pc_i = 32'h0000_0300; if_ready_i = 1'b1;
    ex_load_i = 1'b1; ex_rd_addr_i = 5'd2; id_rs1_re_i = 1'b1; id_rs1_addr_i = 5'd2;
    chk("jmp_over_lu", V_JUMP, 32'h0000_0300);
    tick(); ex_jump_i = 1'b0; ex_jump_pc_i = '0; if_ready_i = 1'b0; ex_busy_i = 1'b1;
    chk("lu_over_busy", V_LU, 32'h0);
    tick(); idle_inputs();
    chk_cnt("prio_cnt", 4'd1);

    // Busy holds the front end every cycle; counter saturates
    ex_busy_i = 1'b1;
    chk("busy0", V_BUSY, 32'h0);
    for (int i = 0; i < 14; i++) tick();
    chk_cnt("busy_15", 4'd15);
    for (int i = 0; i < 6; i++) tick();
    chk("busy20", V_BUSY, 32'h0);
    chk_cnt("busy_sat", 4'd15);
    tick(); idle_inputs();
    chk("busy_end", V_IDLE, 32'h0);
    chk_cnt("busy_end", 4'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised pipeline control unit and successor to the single-source jump-flush controller. It arbitrates flush sources (MEM exception, EX jump) against stall sources (load-use hazard, multicycle EX unit busy). A pending-redirect FSM holds the redirect PC until fetch accepts it, and an optional post-exception drain window is provided. It sits beside the 5-stage pipe and drives the stall and flush controls of the IF (PC), ID, EX and MEM pipeline registers.

Parameters:
PC_WIDTH, 32, width of all PC values
REG_ADDR_W, 5, register index width
DRAIN_CYCLES, 2, cycles fetch is held after an exception before redirect (0 = none)
STALL_CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ex_jump_i  in  1  EX resolved taken jump/branch mispredict
ex_jump_pc_i  in  PC_WIDTH  jump target
mem_excp_i  in  1  exception raised in MEM
mem_excp_pc_i  in  PC_WIDTH  trap vector
ex_load_i  in  1  instruction in EX is a load
ex_rd_addr_i  in  REG_ADDR_W  EX destination register
id_rs1_re_i  in  1  ID reads rs1
id_rs1_addr_i  in  REG_ADDR_W  ID rs1 index
id_rs2_re_i  in  1  ID reads rs2
id_rs2_addr_i  in  REG_ADDR_W  ID rs2 index
ex_busy_i  in  1  multicycle EX unit not done
if_ready_i  in  1  fetch accepts redirect this cycle
if_stall_o  out  1  hold PC
id_stall_o  out  1  hold IF/ID register
ex_stall_o  out  1  hold ID/EX register
if_flush_o  out  1  bubble into IF/ID
id_flush_o  out  1  bubble into ID/EX
ex_flush_o  out  1  bubble into EX/MEM
mem_flush_o  out  1  bubble into MEM/WB
redirect_valid_o  out  1  flush_pc_o is valid
flush_pc_o  out  PC_WIDTH  redirect target
stall_cnt_o  out  STALL_CNT_W  cycles with if_stall_o=1

Behaviour:
- Reset (async, rst_n=0): state=RUN, pend_pc=0, drain_cnt=0, stall_cnt=0. With idle inputs, all outputs are 0.
- Stall/flush/redirect outputs are combinational from state and inputs. The same-cycle response to events matches the previous generation.
- Flush has priority over stall. In a given stage, flush and stall are never both 1.
- Priority order: mem_excp_i > ex_jump_i > load-use > ex_busy_i.
- Load-use condition: ex_load_i && ex_rd_addr_i!=0 && ((id_rs1_re_i && rs1==rd) || (id_rs2_re_i && rs2==rd)).
- FSM states: RUN, DRAIN, WAIT.
- RUN, exception:
  - if/id/ex/mem_flush_o=1.
  - Latch pend_pc=mem_excp_pc_i.
  - If DRAIN_CYCLES>0: drain_cnt=DRAIN_CYCLES-1, go to DRAIN. Otherwise go to WAIT.
  - No redirect in this cycle.
- RUN, jump:
  - if_flush_o=1, id_flush_o=1.
  - redirect_valid_o=1, flush_pc_o=ex_jump_pc_i.
  - If if_ready_i=1, stay in RUN. Otherwise latch pend_pc and go to WAIT.
- RUN, load-use: if_stall_o=1, id_stall_o=1, id_flush_o=1 (bubble into EX). Duration is 1 cycle per hazard.
- RUN, ex_busy_i: if_stall_o=1, id_stall_o=1, ex_stall_o=1, ex_flush_o=1 (bubble into MEM). Holds for as long as busy is asserted.
- DRAIN:
  - if_stall_o=1, if_flush_o=1, redirect_valid_o=0.
  - Decrement drain_cnt. When it reaches 0, go to WAIT.
- WAIT:
  - redirect_valid_o=1, flush_pc_o=pend_pc, if_stall_o=1, if_flush_o=1.
  - On if_ready_i=1, go to RUN. Fetch resumes from pend_pc next cycle.
- Exception in DRAIN or WAIT: full flush, overwrite pend_pc, restart DRAIN. The newest exception wins.
- ex_jump_i outside RUN: ignored, because EX holds only bubbles; the bench flags it with an assertion.
- stall_cnt: increments each cycle if_stall_o=1. Saturates at all-ones and does not wrap.
- Reset mid-DRAIN/WAIT: pending redirect is discarded and the FSM returns to RUN.

Decomposition:
- Shared package: FSM state encoding (RUN/DRAIN/WAIT, 2 bits), flush-source priority constants. PC_WIDTH comes from the existing global defines.
- Sub-module hazard_detect: purely combinational load-use compare. It keeps the controller FSM readable and is unit-testable alone.

Test Plan:
- Load-use: ex_load_i=1, rd=5, id_rs1_re_i=1, rs1=5 for 1 cycle -> if/id_stall_o=1 and id_flush_o=1 for exactly 1 cycle; stall_cnt_o=1. Repeat with rd=0 -> no stall.
- Jump, fetch ready: ex_jump_i=1, pc=0x0000_0100, if_ready_i=1 -> same cycle if/id_flush_o=1, redirect_valid_o=1, flush_pc_o=0x100; FSM stays in RUN.
- Jump, fetch not ready: if_ready_i=0 for 3 cycles after a jump to 0x200 -> redirect_valid_o held 4 cycles with flush_pc_o=0x200, if_stall_o=1; RUN on the cycle if_ready_i=1.
- Exception, DRAIN_CYCLES=2: mem_excp_i to 0x8000_0000 -> all four flushes in cycle 0; redirect_valid_o=0 in cycles 1-2; redirect_valid_o=1 with 0x8000_0000 from cycle 3.
- Simultaneous: mem_excp_i, ex_jump_i, load-use and ex_busy_i all high -> only the exception response (ex/mem_flush_o=1, no stalls); pend_pc=mem_excp_pc_i.
- Reset during WAIT and stall_cnt saturation: rst_n low mid-WAIT -> outputs 0 immediately. With STALL_CNT_W=4, 20 busy cycles -> stall_cnt_o=15.
